// File: rtl/io_wb_pkg.sv
// io_wb_pkg -- shared definitions for the PSoC IO Wishbone initiator.
//   wb_state_t      : initiator FSM encoding (IDLE -> BUS -> RESP -> IDLE)
//   GPIO_OE/GPIO_FN/HWID : IO register file byte offsets
//   HWID_MAGIC      : upper half of the HWID register
//   ack_rdata()     : response data captured on a normal ack
package io_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  localparam logic [31:0] GPIO_OE    = 32'h0000_0000;
  localparam logic [31:0] GPIO_FN    = 32'h0000_0004;
  localparam logic [31:0] HWID       = 32'h0000_0008;
  localparam logic [15:0] HWID_MAGIC = 16'hB50C;

  // Writes return zero data; reads return whatever the slave presented with ack.
  function automatic logic [31:0] ack_rdata(input logic we, input logic [31:0] dat);
    return we ? 32'h0 : dat;
  endfunction

endpackage

// File: rtl/io_wb_master_if.sv
// io_wb_master_if -- command/response handshake plus Wishbone initiator bus.
//   cmd_*   : command port (valid/ready), write flag, byte address, write data, byte enables
//   rsp_*   : response port (valid/ready), read data, error flag
//   wb_*_o  : Wishbone initiator outputs; wb_*_i : slave returns
//   modport master : the initiator (io_wb_master)
//   modport slave  : the environment side (command source, response sink, Wishbone slave)
interface io_wb_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/io_wb_timeout.sv
// io_wb_timeout -- bus-cycle watchdog for io_wb_master (used only when
// IO_WB_MASTER_TIMEOUT_EN is defined).
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart count (command accepted, BUS about to begin)
//   en       : one BUS cycle elapses
//   expired  : this BUS cycle is cycle number TIMEOUT_CYCLES
module io_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt counts completed BUS cycles, so cnt == N-1 marks the N-th one.
  assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/io_wb_master.sv
// io_wb_master -- Wishbone classic initiator for the PSoC IO subsystem.
// Turns one command from the valid/ready command port into exactly one
// Wishbone cycle and returns read data / error on the response port.
// Only one transaction is ever outstanding.
//   clk  : system clock
//   rst  : asynchronous active-low reset (0 = reset asserted)
//   bus  : io_wb_master_if.master (cmd_*, rsp_*, wb_*)
// Build option: define IO_WB_MASTER_TIMEOUT_EN to abort a BUS phase that sees
// no ack/err for TIMEOUT_CYCLES cycles (reported as an error response).
// Without it, TIMEOUT_CYCLES is ignored and BUS waits indefinitely.
module io_wb_master
  import io_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  io_wb_master_if.master bus
);

  wb_state_t state;
  logic      accept;
  logic      tmo_expired;
  logic      bus_done;

  assign accept      = (state == ST_IDLE) && bus.cmd_valid;
  assign bus.cmd_ready = (state == ST_IDLE);

`ifdef IO_WB_MASTER_TIMEOUT_EN
  io_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == ST_BUS),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_expired        = 1'b0;
`endif

  // ack/err only mean something while a cycle is in flight; the trailing ack
  // a registered-ack slave produces after cyc drops lands in RESP and is ignored.
  assign bus_done = (state == ST_BUS) && (bus.wb_ack_i || bus.wb_err_i || tmo_expired);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_sel_o <= '0;
      bus.wb_we_o  <= 1'b0;
      bus.wb_cyc_o <= 1'b0;
      bus.wb_stb_o <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat  <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      case (state)
        // IDLE: launch the cycle; address/data stay put afterwards (cyc qualifies them)
        ST_IDLE: begin
          if (accept) begin
            bus.wb_adr_o <= bus.cmd_adr;
            bus.wb_dat_o <= bus.cmd_dat;
            bus.wb_sel_o <= bus.cmd_sel;
            bus.wb_we_o  <= bus.cmd_we;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            state        <= ST_BUS;
          end
        end

        // BUS: wb_*_o held; err beats ack, and a real ack/err beats the watchdog
        ST_BUS: begin
          if (bus.wb_err_i) begin
            bus.rsp_dat <= '0;
            bus.rsp_err <= 1'b1;
          end else if (bus.wb_ack_i) begin
            bus.rsp_dat <= ack_rdata(bus.wb_we_o, bus.wb_dat_i);
            bus.rsp_err <= 1'b0;
          end else if (tmo_expired) begin
            bus.rsp_dat <= '0;
            bus.rsp_err <= 1'b1;
          end
          if (bus_done) begin
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end
        end

        // RESP: response held for as long as the consumer stalls
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: begin
          bus.wb_cyc_o  <= 1'b0;
          bus.wb_stb_o  <= 1'b0;
          bus.rsp_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_wb_master.sv
// tb_io_wb_master -- bench for io_wb_master with a registered-ack IO register
// file slave (GPIO_OE, GPIO_FN, HWID) and a behavioural register model.
module tb_io_wb_master;
  import io_wb_pkg::*;

  localparam logic [15:0] SYSINFO = 16'h1234;
  localparam int M_NORMAL = 0;
  localparam int M_ERR    = 1;
  localparam int M_SILENT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   slv_mode = M_NORMAL;
  int   n_vec = 0;
  int   n_err = 0;

  io_wb_master_if bus();

  io_wb_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave: register file, ack/err registered from cyc&stb
  logic [31:0] slv_oe, slv_fn;

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    case (a)
      GPIO_OE: return slv_oe;
      GPIO_FN: return slv_fn;
      HWID:    return {HWID_MAGIC, SYSINFO};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wb_ack_i <= 1'b0;
      bus.wb_err_i <= 1'b0;
      bus.wb_dat_i <= 32'h0;
    end else begin
      bus.wb_ack_i <= bus.wb_cyc_o && bus.wb_stb_o && (slv_mode != M_SILENT);
      bus.wb_err_i <= bus.wb_cyc_o && bus.wb_stb_o && (slv_mode == M_ERR);
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        bus.wb_dat_i <= slv_rd(bus.wb_adr_o);
        if (bus.wb_we_o && slv_mode == M_NORMAL) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.wb_sel_o[b]) begin
              if (bus.wb_adr_o == GPIO_OE) slv_oe[8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
              if (bus.wb_adr_o == GPIO_FN) slv_fn[8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------- reference model: what each transaction should return
  logic [31:0] ref_oe = 32'h0;
  logic [31:0] ref_fn = 32'h0;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction: model prediction, launch, latency, hold, consume.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int stall);
    logic [31:0] exp_dat;
    logic        exp_err;
    int          lat, rises;
    logic        prev_cyc;
    if (slv_mode == M_ERR) begin
      exp_dat = 32'h0;
      exp_err = 1'b1;
    end else if (we) begin
      exp_dat = 32'h0;
      exp_err = 1'b0;
      if (adr == GPIO_OE) ref_oe = (ref_oe & ~sel_mask(sel)) | (dat & sel_mask(sel));
      if (adr == GPIO_FN) ref_fn = (ref_fn & ~sel_mask(sel)) | (dat & sel_mask(sel));
    end else begin
      exp_err = 1'b0;
      exp_dat = (adr == GPIO_OE) ? ref_oe :
                (adr == GPIO_FN) ? ref_fn :
                (adr == HWID)    ? {16'hB50C, 16'h1234} : 32'h0;
    end

    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    chk("cyc_stb_on", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd3);
    chk("wb_adr", bus.wb_adr_o, adr);
    chk("wb_dat", bus.wb_dat_o, dat);
    chk("wb_sel_we", 32'({bus.wb_sel_o, bus.wb_we_o}), 32'({sel, we}));
    chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);

    lat = 1; rises = 1; prev_cyc = 1'b1;
    while (!bus.rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
      if (bus.wb_cyc_o && !prev_cyc) rises++;
      prev_cyc = bus.wb_cyc_o;
    end
    chk("rsp_latency", 32'(lat), 32'd3);
    chk("cyc_pulses", 32'(rises), 32'd1);
    chk("rsp_dat", bus.rsp_dat, exp_dat);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));

    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_dat", bus.rsp_dat, exp_dat);
      chk("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      chk("hold_busy", 32'({bus.cmd_ready, bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_consumed", 32'(bus.rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
  endtask

  // Launch a command the silent slave never answers; leaves the DUT in BUS.
  task automatic launch_silent(input logic [31:0] adr);
    slv_mode = M_SILENT;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = adr;
    bus.cmd_sel   = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    slv_mode = M_NORMAL;
  endtask

  initial begin
    int cyc_cnt;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h0;
    bus.cmd_dat   = 32'h0;
    bus.cmd_sel   = 4'h0;
    bus.rsp_ready = 1'b0;
    slv_oe = 32'h0;
    slv_fn = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset_wb", bus.wb_adr_o | bus.wb_dat_o, 32'h0);
    chk("reset_ctl", 32'({bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o,
                          bus.rsp_valid, bus.rsp_err}), 32'd0);
    chk("reset_rsp_dat", bus.rsp_dat, 32'h0);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b1;

    // Directed: write/readback, HWID read, long response stall, error cycle
    txn(1'b1, GPIO_OE, 32'h003F_FFFF, 4'b0111, 0);
    txn(1'b0, GPIO_OE, 32'h0, 4'hF, 0);
    txn(1'b0, HWID, 32'h0, 4'hF, 0);
    txn(1'b0, HWID, 32'h0, 4'hF, 10);
    slv_mode = M_ERR;
    txn(1'b0, GPIO_OE, 32'h0, 4'hF, 1);
    txn(1'b1, GPIO_FN, 32'hDEAD_BEEF, 4'hF, 0);
    slv_mode = M_NORMAL;

    // Reset while cyc is high: cycle dropped, next command completes
    launch_silent(GPIO_FN);
    repeat (2) @(negedge clk);
    chk("silent_cyc_high", 32'(bus.wb_cyc_o), 32'd1);
    pulse_reset();
    txn(1'b0, GPIO_FN, 32'h0, 4'hF, 0);

    // Randomised traffic
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0:       a = GPIO_OE;
        1:       a = GPIO_FN;
        default: a = HWID;
      endcase
      slv_mode = ($urandom_range(0, 5) == 0) ? M_ERR : M_NORMAL;
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3));
    end
    slv_mode = M_NORMAL;

    // Unanswered cycle: aborted by the watchdog, or held forever without it
    launch_silent(GPIO_OE);
    cyc_cnt = 0;
`ifdef IO_WB_MASTER_TIMEOUT_EN
    while (bus.wb_cyc_o && cyc_cnt < 40) begin
      cyc_cnt++;
      @(negedge clk);
    end
    chk("timeout_cyc_cycles", 32'(cyc_cnt), 32'd8);
    chk("timeout_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("timeout_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("timeout_rsp_dat", bus.rsp_dat, 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    slv_mode = M_NORMAL;
`else
    while (bus.wb_cyc_o && cyc_cnt < 1000) begin
      cyc_cnt++;
      @(negedge clk);
    end
    chk("no_timeout_cyc_cycles", 32'(cyc_cnt), 32'd1000);
    chk("no_timeout_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    pulse_reset();
`endif
    txn(1'b0, GPIO_OE, 32'h0, 4'hF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
